ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle RV32M multiply/divide execute unit, parametrised in datapath width, sitting beside the single-cycle ALU in the EX stage. It accepts one operation at a time through a start/valid handshake and runs an iterative radix-2 shift-add multiplier or restoring divider. It returns the result together with the destination register address and write-enable. While it is busy, the pipeline stalls through `busy_o`.

## Interface
- `XLEN`, 32: operand/result width; must be ≥ 8 and even.
- `REG_ADDR_W`, 5: destination register address width.
- `CNT_W`, $clog2(XLEN)+1: iteration counter width.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start_i` input 1: request a new operation; sampled only in IDLE.
- `op_i` input 3: RV32M funct3 encoding.
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_i` input XLEN: operand A (multiplicand/dividend).
- `rs2_i` input XLEN: operand B (multiplier/divisor).
- `wd_i` input REG_ADDR_W: destination register.
- `wreg_i` input 1: write-enable to forward.
- `flush_i` input 1: abort any in-flight operation.
- `busy_o` output 1: high whenever state ≠ IDLE.
- `valid_o` output 1: one-cycle result strobe.
- `wdata_o` output XLEN: result; meaningful only while `valid_o` is high.
- `wd_o` output REG_ADDR_W: captured `wd_i`.
- `wreg_o` output 1: captured `wreg_i` AND `valid_o`.

## Operation
- States:
  - IDLE: wait for `start_i`.
  - CALC: run iterations.
  - DONE: present the result.
- IDLE → CALC on `start_i`. In the same edge the unit captures `op_i`, `wd_i`, `wreg_i`, the operand magnitudes and the result-sign flags, and clears the counter.
- Signedness of operands:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both signed.
  - All other operations are unsigned.
- CALC performs one iteration per cycle; after XLEN iterations it moves to DONE.
  - Multiply: 2·XLEN-bit accumulator, one shift-add per cycle.
  - Divide: restoring divide, one quotient bit per cycle; remainder held in XLEN+1 bits.
- Leaving CALC registers the sign-corrected result into `wdata_o`:
  - MUL returns the product's low XLEN bits; MULH/MULHSU/MULHU return its high XLEN bits.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- DONE: `valid_o`=1 for exactly one cycle, then the unit returns to IDLE unconditionally.
- Division special cases; the values are identical in both configurations:
  - Divisor 0: quotient = all-ones, remainder = rs1.
  - Signed overflow (A = −2^(XLEN−1), B = −1): quotient = A, remainder = 0.
- `start_i` is ignored outside IDLE; there is no queueing.
- `flush_i` in any state → IDLE on the next edge, with `valid_o` suppressed.
  - `flush_i` and `start_i` in the same IDLE cycle: flush wins and the start is dropped.
- `rst` → IDLE. Reset values: `busy_o`=0, `valid_o`=0, `wdata_o`=0, `wd_o`=0, `wreg_o`=0.
  - Reset mid-operation discards the operation with no strobe.

## Timing
- Cycle T is the cycle in which `start_i` is sampled high in IDLE.
- `busy_o` is high from T+1 through the DONE cycle.
- Normal latency: CALC spans T+1…T+XLEN; DONE (`valid_o`) is at T+XLEN+1. With XLEN=32 that is T+33.
- Earliest next start: T+XLEN+2, because DONE always returns to IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MULDIV_FASTDIV_EN` defined:
  - A divide-by-zero or signed overflow detected at T skips CALC: DONE at T+1, `valid_o` at T+1.
  - Multiplies and other divides are unaffected.
- Undefined: every operation takes the full XLEN+1-cycle latency; result values are unchanged.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, wd=5, wreg=1 → at T+33: `valid_o`=1, `wdata_o`=0xFFFFFFEB, `wd_o`=5, `wreg_o`=1; `busy_o` high T+1…T+33.
- All operands = 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
  - With `MULDIV_FASTDIV_EN`: `valid_o` at T+1.
  - Without it: `valid_o` at T+33.
- `flush_i` at T+10 → `busy_o`=0 at T+11 and no `valid_o` ever; a new start at T+11 completes normally at T+44.
- `start_i` held high during CALC with different operands → ignored, the first result is unchanged; `rst` at T+5 → all outputs 0 at T+6, no strobe.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide execute unit.
// Iterative radix-2 shift-add multiplier and restoring divider working on
// operand magnitudes, with the sign applied when the result is registered.
// Optional build macro: MULDIV_FASTDIV_EN -- divide-by-zero and signed
// overflow are resolved in the start cycle instead of iterating.
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = $clog2(XLEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       rs1_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t                  state;
  logic [2:0]              op_q;
  logic [REG_ADDR_W-1:0]   wd_q;
  logic                    wreg_q;
  logic                    neg_q;       // quotient / product sign
  logic                    neg_r;       // remainder sign
  logic                    div_zero_q;
  logic [XLEN-1:0]         opa;         // multiplicand magnitude
  logic [XLEN-1:0]         opb;         // divisor magnitude
  logic [XLEN-1:0]         quo;         // dividend shifting out / quotient shifting in
  logic [XLEN:0]           rem;         // partial remainder
  logic [2*XLEN-1:0]       acc;         // {partial product, multiplier}
  logic [CNT_W-1:0]        cnt;

  logic                    a_signed;
  logic                    b_signed;
  logic                    sign_a;
  logic                    sign_b;
  logic                    div_zero;
  logic [XLEN-1:0]         mag_a;
  logic [XLEN-1:0]         mag_b;
`ifdef MULDIV_FASTDIV_EN
  logic                    div_ovf;
  logic [XLEN-1:0]         fast_res;
`endif

  logic [XLEN:0]           mul_sum;
  logic [2*XLEN-1:0]       mul_next;
  logic [XLEN:0]           div_shift;
  logic                    div_ge;
  logic [XLEN:0]           rem_next;
  logic [XLEN-1:0]         quo_next;
  logic [2*XLEN-1:0]       prod;
  logic [XLEN-1:0]         quo_fin;
  logic [XLEN-1:0]         rem_fin;
  logic [XLEN-1:0]         result;

  // Decode operand signedness and magnitudes from the incoming request
  always_comb begin
    a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    sign_a   = a_signed & rs1_i[XLEN-1];
    sign_b   = b_signed & rs2_i[XLEN-1];
    mag_a    = sign_a ? (~rs1_i + 1'b1) : rs1_i;
    mag_b    = sign_b ? (~rs2_i + 1'b1) : rs2_i;
    div_zero = op_i[2] && (rs2_i == '0);
`ifdef MULDIV_FASTDIV_EN
    div_ovf  = op_i[2] && !op_i[0] && (rs1_i == SMIN) && (rs2_i == '1);
    if (div_zero)
      fast_res = op_i[1] ? rs1_i : '1;
    else
      fast_res = op_i[1] ? '0 : rs1_i;
`endif
  end

  // One iteration step of each datapath plus sign-corrected final result
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {rem[XLEN-1:0], quo[XLEN-1]};
    // rem[XLEN] set means the shifted remainder already exceeds any divisor
    div_ge    = rem[XLEN] || (div_shift >= {1'b0, opb});
    rem_next  = div_ge ? (div_shift - {1'b0, opb}) : div_shift;
    quo_next  = {quo[XLEN-2:0], div_ge};
    prod      = neg_q ? (~mul_next + 1'b1) : mul_next;
    // Divide-by-zero forces all-ones; the remainder path already yields rs1,
    // and signed overflow falls out of the magnitude arithmetic unchanged.
    if (div_zero_q)
      quo_fin = '1;
    else
      quo_fin = neg_q ? (~quo_next + 1'b1) : quo_next;
    rem_fin   = neg_r ? (~rem_next[XLEN-1:0] + 1'b1) : rem_next[XLEN-1:0];
    if (!op_q[2])
      result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else
      result = op_q[1] ? rem_fin : quo_fin;
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      wdata_o <= '0;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
    end else if (flush_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          wreg_o  <= 1'b0;
          if (start_i) begin
            op_q       <= op_i;
            wd_q       <= wd_i;
            wreg_q     <= wreg_i;
            neg_q      <= sign_a ^ sign_b;
            neg_r      <= sign_a;
            div_zero_q <= div_zero;
            opa        <= mag_a;
            opb        <= mag_b;
            acc        <= {{XLEN{1'b0}}, mag_b};
            quo        <= mag_a;
            rem        <= '0;
            cnt        <= '0;
            state      <= CALC;
            busy_o     <= 1'b1;
`ifdef MULDIV_FASTDIV_EN
            if (div_zero || div_ovf) begin
              state   <= DONE;
              valid_o <= 1'b1;
              wdata_o <= fast_res;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
            end
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[2]) begin
            quo <= quo_next;
            rem <= rem_next;
          end else begin
            acc <= mul_next;
          end
          if (cnt == CNT_W'(XLEN - 1)) begin
            state   <= DONE;
            valid_o <= 1'b1;
            wdata_o <= result;
            wd_o    <= wd_q;
            wreg_o  <= wreg_q;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
          wreg_o  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv (XLEN=32) against a
// 64-bit arithmetic reference model, with directed and random operations.
module tb_ex_muldiv;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [RAW-1:0]  wd_i;
  logic            wreg_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] wdata_o;
  logic [RAW-1:0]  wd_o;
  logic            wreg_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(RAW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .wd_i    (wd_i),
    .wreg_i  (wreg_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .wdata_o (wdata_o),
    .wd_o    (wd_o),
    .wreg_o  (wreg_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result straight from RV32M arithmetic rules
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_FASTDIV_EN
    if (op[2] && (b == 32'd0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Issue one operation in the current cycle (called at a negedge) and check
  // the strobe timing, payload, busy window and the return to idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg, input bit hold,
                        input string tag);
    int          lat;
    int          got;
    int          busy_low;
    logic [31:0] exp_data;
    logic [31:0] got_data;
    logic [4:0]  got_wd;
    logic        got_wreg;
    exp_data = ref_result(op, a, b);
    lat      = ref_latency(op, a, b);
    op_i = op; rs1_i = a; rs2_i = b; wd_i = wd; wreg_i = wreg; start_i = 1'b1;
    got = 0; busy_low = 0; got_data = '0; got_wd = '0; got_wreg = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (hold) begin
        op_i  = 3'($urandom_range(0, 7));
        rs1_i = $urandom();
        rs2_i = $urandom();
        wd_i  = 5'($urandom());
      end else begin
        start_i = 1'b0;
      end
      if (!busy_o) busy_low++;
      if (valid_o) begin
        got      = k;
        got_data = wdata_o;
        got_wd   = wd_o;
        got_wreg = wreg_o;
        break;
      end
    end
    start_i = 1'b0;
    check({tag, " latency"}, got, lat);
    check({tag, " wdata"}, got_data, exp_data);
    check({tag, " wd"}, {27'b0, got_wd}, {27'b0, wd});
    check({tag, " wreg"}, {31'b0, got_wreg}, {31'b0, wreg});
    check({tag, " busy window"}, busy_low, 0);
    @(negedge clk);
    check({tag, " strobe width"}, {31'b0, valid_o}, 32'd0);
    check({tag, " idle busy"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    wd_i = '0; wreg_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy_o}, 32'd0);
    check("reset valid", {31'b0, valid_o}, 32'd0);
    check("reset wdata", wdata_o, 32'd0);
    check("reset wd", {27'b0, wd_o}, 32'd0);
    check("reset wreg", {31'b0, wreg_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back to back at the earliest restart point
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 1'b0, "mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 1'b0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 1'b0, "rem");
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b1, 1'b0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b1, 1'b0, "remu");
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 1'b1, 1'b0, "divu by zero");
    run_op(3'd7, 32'd5, 32'd0, 5'd10, 1'b1, 1'b0, "remu by zero");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd11, 1'b1, 1'b0, "div by zero");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd12, 1'b1, 1'b0, "rem by zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b0, "div overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 1'b0, "rem overflow");

    // Flush mid-calculation: no strobe, idle next cycle, restart right away
    op_i = 3'd0; rs1_i = 32'd123; rs2_i = 32'd456; wd_i = 5'd15; wreg_i = 1'b1;
    start_i = 1'b1; vcount = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (valid_o) vcount++;
      if (k == 10) flush_i = 1'b1;
      if (k == 11) begin
        check("flush busy", {31'b0, busy_o}, 32'd0);
        flush_i = 1'b0;
      end
    end
    check("flush no strobe", vcount, 0);
    run_op(3'd5, 32'd1000, 32'd3, 5'd16, 1'b1, 1'b0, "after flush");

    // Flush and start together in idle: the start is dropped
    op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush beats start", {31'b0, busy_o}, 32'd0);

    // start held during CALC with changing operands must not disturb the result
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 1'b1, 1'b1, "start held");

    // Reset mid-operation: outputs clear and no strobe ever appears
    op_i = 3'd4; rs1_i = 32'd77; rs2_i = 32'd5; wd_i = 5'd18; wreg_i = 1'b1;
    start_i = 1'b1; vcount = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (valid_o) vcount++;
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        check("mid rst busy", {31'b0, busy_o}, 32'd0);
        check("mid rst valid", {31'b0, valid_o}, 32'd0);
        check("mid rst wdata", wdata_o, 32'd0);
        check("mid rst wd", {27'b0, wd_o}, 32'd0);
        check("mid rst wreg", {31'b0, wreg_o}, 32'd0);
        rst = 1'b0;
      end
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    check("mid rst no strobe", vcount, 0);

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             5'($urandom()), 1'($urandom_range(0, 1)), 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
